icache: RTL and testbench

Direct-mapped, read-only instruction cache between the pipelined datapath's fetch port and the memory controller's instruction port. Hits return the instruction combinationally in the cycle of the request. Misses fetch one word from memory through a two-state controller and install it. Two saturating-free performance counters record hits and misses for CPI analysis.

---
 rtl/cpu_types_pkg.sv | 25 ++
 rtl/caches_if.sv | 19 +
 rtl/datapath_cache_if.sv | 21 ++
 rtl/icache.sv | 104 ++++++++++
 tb/tb_icache.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU cache types: fetch-address split, icache frame layout and controller states.
package cpu_types_pkg;

  localparam int IBYT_W = 2;
  localparam int IIDX_W = 4;
  localparam int ITAG_W = 32 - IIDX_W - IBYT_W;

  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [IBYT_W-1:0] bytoff;
  } icachef_t;

  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    logic [31:0]       data;
  } icache_frame_t;

  typedef enum logic {
    IDLE = 1'b0,
    MISS = 1'b1
  } icache_state_t;

endpackage

// File: rtl/caches_if.sv
// Cache <-> memory controller instruction port.
interface caches_if;

  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport icache (
    output iREN, iaddr,
    input  iwait, iload
  );

  modport mem (
    input  iREN, iaddr,
    output iwait, iload
  );

endinterface

// File: rtl/datapath_cache_if.sv
// Datapath <-> cache fetch port, plus the icache performance counters.
interface datapath_cache_if;

  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport icache (
    input  imemREN, imemaddr,
    output ihit, imemload, hit_count, miss_count
  );

  modport datapath (
    output imemREN, imemaddr,
    input  ihit, imemload, hit_count, miss_count
  );

endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: combinational hit, one-word fill on miss.
// Hit latency 0; miss penalty is memory wait cycles + 2; iREN held for the whole fill.
module icache
  import cpu_types_pkg::*;
#(
  parameter int NSETS = 16,
  parameter int IDX_W = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  datapath_cache_if.icache      dcif,
  caches_if.icache              cif
);

  icache_state_t     state_q, state_d;
  icache_frame_t     frames_q [NSETS];
  logic [ITAG_W-1:0] miss_tag_q, miss_tag_d;
  logic [IDX_W-1:0]  miss_idx_q, miss_idx_d;
  logic              iren_q, iren_d;
  logic [31:0]       iaddr_q, iaddr_d;
  logic [31:0]       hit_cnt_q, hit_cnt_d;
  logic [31:0]       miss_cnt_q, miss_cnt_d;

  icachef_t          fa;
  icache_frame_t     cur;
  logic              lookup_hit;
  logic              ihit;
  logic              fill;
  logic              unused_bytoff;

  assign fa            = dcif.imemaddr;
  assign cur           = frames_q[fa.idx];
  assign lookup_hit    = dcif.imemREN & cur.valid & (cur.tag == fa.tag);
  assign ihit          = (state_q == IDLE) & lookup_hit;
  assign unused_bytoff = ^fa.bytoff;

  assign dcif.ihit       = ihit;
  assign dcif.imemload   = ihit ? cur.data : 32'h0;
  assign dcif.hit_count  = hit_cnt_q;
  assign dcif.miss_count = miss_cnt_q;
  assign cif.iREN        = iren_q;
  assign cif.iaddr       = iaddr_q;

  always_comb begin
    state_d    = state_q;
    miss_tag_d = miss_tag_q;
    miss_idx_d = miss_idx_q;
    iren_d     = iren_q;
    iaddr_d    = iaddr_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    fill       = 1'b0;
    case (state_q)
      IDLE: begin
        if (lookup_hit) begin
          hit_cnt_d = hit_cnt_q + 32'd1;
        end else if (dcif.imemREN) begin
          miss_tag_d = fa.tag;
          miss_idx_d = fa.idx;
          iaddr_d    = {fa.tag, fa.idx, 2'b00};
          iren_d     = 1'b1;
          miss_cnt_d = miss_cnt_q + 32'd1;
          state_d    = MISS;
        end
      end
      MISS: begin
        // The fill targets the latched address; imemREN/imemaddr are ignored here.
        if (!cif.iwait) begin
          fill    = 1'b1;
          iren_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
      iren_q     <= 1'b0;
      iaddr_q    <= 32'h0;
      hit_cnt_q  <= 32'h0;
      miss_cnt_q <= 32'h0;
      for (int i = 0; i < NSETS; i++) begin
        frames_q[i].valid <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      miss_tag_q <= miss_tag_d;
      miss_idx_q <= miss_idx_d;
      iren_q     <= iren_d;
      iaddr_q    <= iaddr_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      if (fill) begin
        frames_q[miss_idx_q] <= '{valid: 1'b1, tag: miss_tag_q, data: cif.iload};
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
// Randomized self-checking bench for icache against an address-arithmetic cache model.
module tb_icache;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  datapath_cache_if dcif ();
  caches_if         cif ();

  icache #(.NSETS(16), .IDX_W(4)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .dcif (dcif),
    .cif  (cif)
  );

  always #5 CLK = ~CLK;

  int vecs = 0;
  int errs = 0;

  // Reference model: 16 one-word frames indexed by (addr/4)%16, tag = addr/64.
  bit          m_valid [16];
  logic [25:0] m_tag   [16];
  logic [31:0] m_data  [16];
  logic [31:0] m_hits;
  logic [31:0] m_misses;
  logic [31:0] m_pend;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (w == 32'h40) return 32'h8C22_0004;
    return w * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 32'd4) % 32'd16);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_hits   = 32'h0;
    m_misses = 32'h0;
  endtask

  // One IDLE-state cycle: present a request, check the lookup and counters.
  task automatic idle_cycle(input logic [31:0] a, input bit ren, output bit missed);
    int          idx;
    bit          h;
    logic [31:0] exp_load;
    @(negedge CLK);
    dcif.imemREN  = ren;
    dcif.imemaddr = a;
    cif.iwait     = 1'b1;
    cif.iload     = $urandom;
    #1;
    idx      = idx_of(a);
    h        = ren && m_valid[idx] && (m_tag[idx] == 26'(a / 32'd64));
    exp_load = h ? m_data[idx] : 32'h0;
    vecs++;
    if (dcif.ihit !== h) begin
      errs++;
      $display("FAIL idle_ihit addr=%h got=%b exp=%b", a, dcif.ihit, h);
    end
    vecs++;
    if (dcif.imemload !== exp_load) begin
      errs++;
      $display("FAIL idle_imemload addr=%h got=%h exp=%h", a, dcif.imemload, exp_load);
    end
    vecs++;
    if (cif.iREN !== 1'b0) begin
      errs++;
      $display("FAIL idle_iren addr=%h got=%b exp=0", a, cif.iREN);
    end
    vecs++;
    if (dcif.hit_count !== m_hits) begin
      errs++;
      $display("FAIL hit_count got=%0d exp=%0d", dcif.hit_count, m_hits);
    end
    vecs++;
    if (dcif.miss_count !== m_misses) begin
      errs++;
      $display("FAIL miss_count got=%0d exp=%0d", dcif.miss_count, m_misses);
    end
    missed = ren && !h;
    if (h) m_hits = m_hits + 1;
    if (missed) begin
      m_misses = m_misses + 1;
      m_pend   = a;
    end
  endtask

  // MISS cycles with L wait cycles. mode 0: hold inputs, 1: switch to alt, 2: random.
  task automatic miss_phase(input int L, input int mode, input logic [31:0] alt);
    int idx;
    for (int k = 1; k <= L + 1; k++) begin
      @(negedge CLK);
      cif.iwait = (k <= L);
      cif.iload = (k == L + 1) ? mem_word(m_pend) : $urandom;
      if (mode == 1) dcif.imemaddr = alt;
      if (mode == 2) begin
        dcif.imemREN  = 1'($urandom);
        dcif.imemaddr = $urandom & 32'h3FF;
      end
      #1;
      vecs++;
      if (cif.iREN !== 1'b1) begin
        errs++;
        $display("FAIL miss_iren cyc=%0d got=%b exp=1", k, cif.iREN);
      end
      vecs++;
      if (cif.iaddr !== (m_pend & 32'hFFFF_FFFC)) begin
        errs++;
        $display("FAIL miss_iaddr got=%h exp=%h", cif.iaddr, m_pend & 32'hFFFF_FFFC);
      end
      vecs++;
      if (dcif.ihit !== 1'b0 || dcif.imemload !== 32'h0) begin
        errs++;
        $display("FAIL miss_ihit got=%b/%h exp=0/0", dcif.ihit, dcif.imemload);
      end
    end
    idx          = idx_of(m_pend);
    m_valid[idx] = 1'b1;
    m_tag[idx]   = 26'(m_pend / 32'd64);
    m_data[idx]  = mem_word(m_pend);
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST          = 1'b1;
    dcif.imemREN = 1'b0;
    cif.iwait    = 1'b1;
    @(negedge CLK);
    #1;
    model_clear();
    vecs++;
    if (dcif.ihit !== 1'b0 || dcif.imemload !== 32'h0) begin
      errs++;
      $display("FAIL reset_ihit got=%b/%h exp=0/0", dcif.ihit, dcif.imemload);
    end
    vecs++;
    if (cif.iREN !== 1'b0 || cif.iaddr !== 32'h0) begin
      errs++;
      $display("FAIL reset_mem got=%b/%h exp=0/0", cif.iREN, cif.iaddr);
    end
    vecs++;
    if (dcif.hit_count !== 32'h0 || dcif.miss_count !== 32'h0) begin
      errs++;
      $display("FAIL reset_counts got=%0d/%0d exp=0/0", dcif.hit_count, dcif.miss_count);
    end
    RST = 1'b0;
  endtask

  task automatic test_first_miss();
    bit m;
    idle_cycle(32'h40, 1'b1, m);
    miss_phase(3, 0, 32'h0);
    idle_cycle(32'h40, 1'b1, m);
  endtask

  task automatic test_rehit();
    bit m;
    for (int i = 0; i < 3; i++) idle_cycle(32'h40, 1'b1, m);
    idle_cycle(32'h40, 1'b0, m);
  endtask

  task automatic test_conflict();
    bit m;
    idle_cycle(32'h80, 1'b1, m);
    miss_phase(1, 0, 32'h0);
    idle_cycle(32'h80, 1'b1, m);
    idle_cycle(32'h40, 1'b1, m);
    miss_phase(0, 0, 32'h0);
    idle_cycle(32'h40, 1'b0, m);
  endtask

  task automatic test_addr_change();
    bit m;
    test_reset();
    idle_cycle(32'h40, 1'b1, m);
    miss_phase(2, 1, 32'h44);
    idle_cycle(32'h44, 1'b1, m);
    miss_phase(1, 0, 32'h0);
    idle_cycle(32'h40, 1'b1, m);
    idle_cycle(32'h44, 1'b1, m);
  endtask

  task automatic test_reset_in_miss();
    bit m;
    test_reset();
    idle_cycle(32'h40, 1'b1, m);
    @(negedge CLK);
    cif.iwait = 1'b1;
    #1;
    vecs++;
    if (cif.iREN !== 1'b1) begin
      errs++;
      $display("FAIL rim_iren1 got=%b exp=1", cif.iREN);
    end
    @(negedge CLK);
    RST       = 1'b1;
    cif.iwait = 1'b0;
    cif.iload = mem_word(32'h40);
    #1;
    vecs++;
    if (cif.iREN !== 1'b1) begin
      errs++;
      $display("FAIL rim_iren2 got=%b exp=1", cif.iREN);
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_clear();
    idle_cycle(32'h40, 1'b1, m);
    miss_phase(0, 0, 32'h0);
    idle_cycle(32'h40, 1'b1, m);
  endtask

  task automatic test_fill_all();
    bit m;
    test_reset();
    for (int i = 0; i < 16; i++) begin
      idle_cycle(32'(i * 4), 1'b1, m);
      miss_phase(int'($urandom_range(0, 3)), 0, 32'h0);
    end
    for (int i = 0; i < 16; i++) idle_cycle(32'(i * 4), 1'b1, m);
    @(negedge CLK);
    dcif.imemREN = 1'b0;
    #1;
    vecs++;
    if (dcif.hit_count !== 32'd16 || dcif.miss_count !== 32'd16) begin
      errs++;
      $display("FAIL fill_all_counts got=%0d/%0d exp=16/16", dcif.hit_count, dcif.miss_count);
    end
  endtask

  task automatic test_random();
    bit          m;
    logic [31:0] a;
    for (int n = 0; n < 400; n++) begin
      a = $urandom & 32'h3FF;
      idle_cycle(a, $urandom_range(0, 3) != 0, m);
      if (m) miss_phase(int'($urandom_range(0, 4)), 2, 32'h0);
    end
  endtask

  initial begin
    dcif.imemREN  = 1'b0;
    dcif.imemaddr = 32'h0;
    cif.iwait     = 1'b1;
    cif.iload     = 32'h0;
    model_clear();
    m_pend = 32'h0;
    test_reset();
    test_first_miss();
    test_rehit();
    test_conflict();
    test_addr_change();
    test_reset_in_miss();
    test_fill_all();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
